// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
//
// Moore controller for a two-street intersection (street A, street B).
// A street stays green while its sensor reports traffic. When traffic
// stops, the street shows yellow for YELLOW_CYCLES cycles, then turns red,
// and the other street gets green.
//
// Light codes: GREEN=2'b00, YELLOW=2'b01, RED=2'b10 (2'b11 is never driven).
//
// Parameters:
//   YELLOW_CYCLES - cycles each yellow phase lasts (1..255)
//
// Ports:
//   clk  in   1  system clock, rising-edge active
//   rst  in   1  asynchronous active-low reset (0 = reset asserted)
//   ta   in   1  traffic sensor, street A (1 = traffic present)
//   tb   in   1  traffic sensor, street B (1 = traffic present)
//   la   out  2  street A light code
//   lb   out  2  street B light code
// ---------------------------------------------------------------------------
module traffic_light_fsm #(
    parameter int YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb
);

    // Counter must be able to hold YELLOW_CYCLES-1; never narrower than 1 bit.
    localparam int CW = ($clog2(YELLOW_CYCLES + 1) < 1) ? 1 : $clog2(YELLOW_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(YELLOW_CYCLES - 1);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [1:0] {
        S0 = 2'b00,  // A green,  B red
        S1 = 2'b01,  // A yellow, B red
        S2 = 2'b10,  // A red,    B green
        S3 = 2'b11   // A red,    B yellow
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        la      = GREEN;
        lb      = RED;
        case (state_q)
            S0: begin
                la = GREEN;
                lb = RED;
                if (!ta) begin
                    state_d = S1;
                    cnt_d   = '0;
                end
            end
            S1: begin
                la = YELLOW;
                lb = RED;
                // The edge that sees CNT_LAST is the YELLOW_CYCLES-th in S1.
                if (cnt_q == CNT_LAST) begin
                    state_d = S2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S2: begin
                la = RED;
                lb = GREEN;
                if (!tb) begin
                    state_d = S3;
                    cnt_d   = '0;
                end
            end
            S3: begin
                la = RED;
                lb = YELLOW;
                if (cnt_q == CNT_LAST) begin
                    state_d = S0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Corrupted state register: show the reset lights and
                // return to S0 on the next edge.
                la      = GREEN;
                lb      = RED;
                state_d = S0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// Bench for traffic_light_fsm. Two instances share the same stimulus:
// u_dut1 (YELLOW_CYCLES=1) and u_dut3 (YELLOW_CYCLES=3). Expected light
// codes come from a vector table of expected states per DUT, pushed into a
// scoreboard queue when inputs are driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

    logic       clk;
    logic       rst;
    logic       ta;
    logic       tb;
    logic [1:0] la1, lb1, la3, lb3;

    int n_checks = 0;
    int n_errors = 0;

    traffic_light_fsm #(.YELLOW_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la1), .lb(lb1)
    );

    traffic_light_fsm #(.YELLOW_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la3), .lb(lb3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector: inputs at the edge plus the state (0..3 = S0..S3) each DUT
    // must show after that edge.
    typedef struct {
        logic ta;
        logic tb;
        int   s1;
        int   s3;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] la1;
        logic [1:0] lb1;
        logic [1:0] la3;
        logic [1:0] lb3;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [1:0] la_of(int s);
        case (s)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] lb_of(int s);
        case (s)
            2:       return 2'b00;
            3:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic void add(logic a, logic b, int s1, int s3);
        vec_t v;
        v.ta = a; v.tb = b; v.s1 = s1; v.s3 = s3;
        vecs.push_back(v);
    endfunction

    task automatic push_exp(string name, int s1, int s3);
        exp_t e;
        e.name = name;
        e.la1 = la_of(s1); e.lb1 = lb_of(s1);
        e.la3 = la_of(s3); e.lb3 = lb_of(s3);
        sb.push_back(e);
    endtask

    task automatic cmp(string name, string sig, logic [1:0] act, logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s %s: got %b expected %b at %0t", name, sig, act, req, $time);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "la1", la1, e.la1);
        cmp(e.name, "lb1", lb1, e.lb1);
        cmp(e.name, "la3", la3, e.la3);
        cmp(e.name, "lb3", lb3, e.lb3);
        $display("%-10s ta=%b tb=%b rst=%b  y1:(%b,%b) y3:(%b,%b)",
                 e.name, ta, tb, rst, la1, lb1, la3, lb3);
    endtask

    // Drive inputs, record expectation, let one edge pass, then compare.
    task automatic apply(string name, logic a, logic b, int s1, int s3);
        ta = a;
        tb = b;
        push_exp(name, s1, s3);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // Assert reset mid-cycle and check the lights switch before any edge;
    // hold reset across one edge, then release just after it.
    task automatic mid_reset(string name);
        #3;
        rst = 1'b0;
        #1;
        push_exp(name, 0, 0);
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Free-running (ta=tb=0) state sequence after reset, 8 edges.
    int fr1[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int fr3[8] = '{1, 1, 1, 2, 3, 3, 3, 0};

    // Safety: never both streets non-red, never the 2'b11 code.
    always @(negedge clk) begin
        n_checks++;
        if (la1 != 2'b10 && lb1 != 2'b10 || la1 == 2'b11 || lb1 == 2'b11) begin
            n_errors++;
            $display("FAIL safety_y1: la=%b lb=%b expected one RED and no 11", la1, lb1);
        end
        n_checks++;
        if (la3 != 2'b10 && lb3 != 2'b10 || la3 == 2'b11 || lb3 == 2'b11) begin
            n_errors++;
            $display("FAIL safety_y3: la=%b lb=%b expected one RED and no 11", la3, lb3);
        end
    end

    initial begin
        // Main table: free run, street A hold, street B hold with ta toggling,
        // hand-back to A.
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, fr1[i], fr3[i]);
        for (int i = 0; i < 20; i++) add(1'b1, 1'b0, 0, 0);
        add(1'b0, 1'b1, 1, 1);
        add(1'b0, 1'b1, 2, 1);
        add(1'b0, 1'b1, 2, 1);
        add(1'b0, 1'b1, 2, 2);
        for (int i = 0; i < 10; i++) add(logic'(i % 2), 1'b1, 2, 2);
        add(1'b1, 1'b0, 3, 3);
        add(1'b1, 1'b0, 0, 3);
        add(1'b1, 1'b0, 0, 3);
        add(1'b1, 1'b0, 0, 0);
        add(1'b1, 1'b0, 0, 0);

        rst = 1'b0;
        ta  = 1'b0;
        tb  = 1'b0;

        // Reset held for 20 edges.
        for (int i = 0; i < 20; i++) apply("reset_hold", 1'b0, 1'b0, 0, 0);
        rst = 1'b1;

        foreach (vecs[i]) apply("table", vecs[i].ta, vecs[i].tb, vecs[i].s1, vecs[i].s3);

        // Glitch on ta between edges while holding S0.
        ta = 1'b1;
        push_exp("glitch", 0, 0);
        #2 ta = 1'b0;
        #2 ta = 1'b1;
        @(posedge clk);
        #1;
        pop_check();

        // Reset during yellow (y3 mid-S1), then yellow must last 3 again.
        apply("to_s1", 1'b0, 1'b0, 1, 1);
        apply("to_s1b", 1'b0, 1'b0, 2, 1);
        mid_reset("rst_in_s1");
        for (int i = 0; i < 8; i++) apply("after_s1", 1'b0, 1'b0, fr1[i], fr3[i]);

        // Reset during S3 (y3 mid-yellow on street B).
        for (int i = 0; i < 6; i++) apply("to_s3", 1'b0, 1'b0, fr1[i], fr3[i]);
        mid_reset("rst_in_s3");
        for (int i = 0; i < 8; i++) apply("after_s3", 1'b0, 1'b0, fr1[i], fr3[i]);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
